// File: rtl/hawk_pkg.sv
// Shared types and constants for the Hawk camera-to-DMA AXI-Stream packer.
package hawk_pkg;

    localparam int unsigned PIX_PER_BEAT = 4;
    localparam int unsigned BEAT_W       = 64;
    localparam int unsigned KEEP_W       = 8;

    typedef enum logic [1:0] {
        IDLE,
        ARMED,
        CAPTURE,
        DRAIN
    } state_t;

    typedef struct packed {
        logic [BEAT_W-1:0] tdata;
        logic [KEEP_W-1:0] tkeep;
        logic              tlast;
    } axis_beat_t;

    // Byte enables covering the first n_lanes pixel lanes (two bytes per lane).
    function automatic logic [KEEP_W-1:0] keep_for(input logic [2:0] n_lanes);
        logic [KEEP_W-1:0] keep;
        keep = '0;
        for (int i = 0; i < PIX_PER_BEAT; i++) begin
            if (3'(i) < n_lanes) begin
                keep[2*i +: 2] = 2'b11;
            end
        end
        return keep;
    endfunction

endpackage

// File: rtl/axis_beat_fifo.sv
// First-word-fall-through beat FIFO. i_force_last makes the last beat left in the FIFO
// leave with tlast set, so a frame whose tlast beat was dropped still terminates.
module axis_beat_fifo
    import hawk_pkg::*;
#(
    parameter  int unsigned DEPTH = 16,
    localparam int unsigned AW    = $clog2(DEPTH)
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_push,
    input  axis_beat_t i_beat,
    input  logic       i_pop,
    input  logic       i_force_last,
    output axis_beat_t o_beat,
    output logic       o_full,
    output logic       o_empty,
    output logic [AW:0] o_count
);

    axis_beat_t    r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_count;
    logic          r_force;
    logic          w_wr;
    logic          w_rd;
    logic          w_last_one;

    assign o_full     = (r_count == (AW+1)'(DEPTH));
    assign o_empty    = (r_count == '0);
    assign o_count    = r_count;
    assign w_last_one = (r_count == (AW+1)'(1));
    assign w_rd       = i_pop & ~o_empty;
    // A pop in the same cycle frees the slot for a push into a full FIFO.
    assign w_wr       = i_push & (~o_full | w_rd);

    always_ff @(posedge i_clk) begin
        if (w_wr) begin
            r_mem[r_wr_ptr] <= i_beat;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_force  <= 1'b0;
        end else begin
            if (w_wr) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_rd) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            r_count <= r_count + (AW+1)'(w_wr) - (AW+1)'(w_rd);
            if (i_force_last) begin
                r_force <= 1'b1;
            end else if (w_rd && w_last_one) begin
                r_force <= 1'b0;
            end
        end
    end

    // Outputs read as zero while empty so the stream is quiet after reset.
    always_comb begin
        o_beat = '0;
        if (!o_empty) begin
            o_beat       = r_mem[r_rd_ptr];
            o_beat.tlast = r_mem[r_rd_ptr].tlast | (r_force & w_last_one);
        end
    end

endmodule

// File: rtl/hawk_axis_packer.sv
// Single-frame capture of 16-bit camera pixels, packed four per 64-bit AXI-Stream beat
// with tlast on the final beat; loss is flagged rather than back-pressured.
module hawk_axis_packer
    import hawk_pkg::*;
#(
    parameter int unsigned PIX_W      = 16,
    parameter int unsigned FIFO_DEPTH = 16
) (
    input  logic              sys_clk,
    input  logic              sys_rst_n,
    input  logic              capture,
    input  logic [15:0]       image_width,
    input  logic [15:0]       image_height,
    input  logic              pix_valid,
    input  logic              pix_fval,
    input  logic              pix_lval,
    input  logic [PIX_W-1:0]  pix_data,
    output logic [BEAT_W-1:0] m_axis_tdata,
    output logic [KEEP_W-1:0] m_axis_tkeep,
    output logic              m_axis_tlast,
    output logic              m_axis_tvalid,
    input  logic              m_axis_tready,
    output logic              busy,
    output logic              frame_done,
    output logic              err_overflow,
    output logic              err_short,
    output logic              err_cfg
);

    localparam int unsigned CW = $clog2(FIFO_DEPTH);

    state_t            r_state;
    state_t            w_state_nxt;
    logic              r_fval_prev;
    logic [31:0]       r_total;
    logic [31:0]       r_cnt;
    logic [BEAT_W-1:0] r_acc;
    axis_beat_t        r_beat;
    logic              r_beat_vld;
    logic              r_err_overflow;
    logic              r_err_short;
    logic              r_err_cfg;

    logic              w_pix_ok;
    logic              w_fval_rise;
    logic              w_cfg_ok;
    logic [31:0]       w_total;
    logic [31:0]       w_cnt_inc;
    logic [1:0]        w_lane;
    logic              w_cap_accept;
    logic              w_cfg_err;
    logic              w_cap_active;
    logic              w_store;
    logic              w_emit;
    logic              w_short;
    logic [BEAT_W-1:0] w_acc_nxt;
    axis_beat_t        w_beat_nxt;

    axis_beat_t        w_fifo_beat;
    logic              w_fifo_full;
    logic              w_fifo_empty;
    logic [CW:0]       w_fifo_count;
    logic              w_pop;
    logic              w_drop;
    logic              w_force_last;

    assign w_pix_ok    = pix_valid & pix_fval & pix_lval;
    assign w_fval_rise = pix_fval & ~r_fval_prev;
    assign w_cfg_ok    = (image_width != '0) && (image_height != '0);
    assign w_total     = 32'(image_width) * 32'(image_height);
    assign w_cnt_inc   = r_cnt + 32'd1;
    assign w_lane      = r_cnt[1:0];

    always_comb begin
        w_state_nxt  = r_state;
        w_cap_accept = 1'b0;
        w_cfg_err    = 1'b0;
        w_store      = 1'b0;
        w_emit       = 1'b0;
        w_short      = 1'b0;
        w_acc_nxt    = r_acc;
        w_beat_nxt   = '0;

        unique case (r_state)
            IDLE: begin
                if (capture) begin
                    if (w_cfg_ok) begin
                        w_cap_accept = 1'b1;
                        w_acc_nxt    = '0;
                        w_state_nxt  = ARMED;
                    end else begin
                        w_cfg_err = 1'b1;
                    end
                end
            end
            ARMED: begin
                if (w_fval_rise) begin
                    w_state_nxt = CAPTURE;
                end
            end
            CAPTURE: begin
            end
            DRAIN: begin
                if (w_pop && w_fifo_beat.tlast && (w_fifo_count == (CW+1)'(1))) begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase

        // The pixel on the fval rising-edge cycle already belongs to the frame.
        w_cap_active = (r_state == CAPTURE) || ((r_state == ARMED) && w_fval_rise);
        if (w_cap_active) begin
            if (w_pix_ok) begin
                w_store = 1'b1;
                for (int i = 0; i < PIX_PER_BEAT; i++) begin
                    if (w_lane == 2'(i)) begin
                        w_acc_nxt[i*PIX_W +: PIX_W] = pix_data;
                    end
                end
                if ((w_lane == 2'd3) || (w_cnt_inc == r_total)) begin
                    w_emit           = 1'b1;
                    w_beat_nxt.tdata = w_acc_nxt;
                    w_beat_nxt.tkeep = keep_for({1'b0, w_lane} + 3'd1);
                    w_beat_nxt.tlast = (w_cnt_inc == r_total);
                    w_acc_nxt        = '0;
                end
                if (w_cnt_inc == r_total) begin
                    w_state_nxt = DRAIN;
                end
            end else if (!pix_fval) begin
                // Frame ended early: flush what we have (possibly nothing) as the last beat.
                w_emit           = 1'b1;
                w_short          = 1'b1;
                w_beat_nxt.tdata = r_acc;
                w_beat_nxt.tkeep = keep_for({1'b0, w_lane});
                w_beat_nxt.tlast = 1'b1;
                w_acc_nxt        = '0;
                w_state_nxt      = DRAIN;
            end
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_fval_prev    <= 1'b0;
            r_total        <= '0;
            r_cnt          <= '0;
            r_acc          <= '0;
            r_beat         <= '0;
            r_beat_vld     <= 1'b0;
            r_err_overflow <= 1'b0;
            r_err_short    <= 1'b0;
            r_err_cfg      <= 1'b0;
        end else begin
            r_fval_prev <= pix_fval;
            r_acc       <= w_acc_nxt;
            r_beat_vld  <= w_emit;
            if (w_emit) begin
                r_beat <= w_beat_nxt;
            end
            if (w_cap_accept) begin
                r_total        <= w_total;
                r_cnt          <= '0;
                r_err_overflow <= 1'b0;
                r_err_short    <= 1'b0;
                r_err_cfg      <= 1'b0;
            end else if (w_store) begin
                r_cnt <= w_cnt_inc;
            end
            if (w_cfg_err) begin
                r_err_cfg <= 1'b1;
            end
            if (w_short) begin
                r_err_short <= 1'b1;
            end
            if (w_drop) begin
                r_err_overflow <= 1'b1;
            end
        end
    end

    assign w_pop        = ~w_fifo_empty & m_axis_tready;
    assign w_drop       = r_beat_vld & w_fifo_full & ~w_pop;
    assign w_force_last = w_drop & r_beat.tlast;

    axis_beat_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .i_clk        (sys_clk),
        .i_rst_n      (sys_rst_n),
        .i_push       (r_beat_vld),
        .i_beat       (r_beat),
        .i_pop        (w_pop),
        .i_force_last (w_force_last),
        .o_beat       (w_fifo_beat),
        .o_full       (w_fifo_full),
        .o_empty      (w_fifo_empty),
        .o_count      (w_fifo_count)
    );

    assign m_axis_tdata  = w_fifo_beat.tdata;
    assign m_axis_tkeep  = w_fifo_beat.tkeep;
    assign m_axis_tlast  = w_fifo_beat.tlast;
    assign m_axis_tvalid = ~w_fifo_empty;
    assign busy          = (r_state != IDLE);
    assign frame_done    = w_pop & w_fifo_beat.tlast;
    assign err_overflow  = r_err_overflow;
    assign err_short     = r_err_short;
    assign err_cfg       = r_err_cfg;

endmodule

// File: tb/tb_hawk_axis_packer.sv
// Directed bench for hawk_axis_packer: expected beats are queued as frames are planned and
// compared against every beat the DMA side accepts.
module tb_hawk_axis_packer;
    import hawk_pkg::*;

    localparam int unsigned DEPTH = 4;

    logic        sys_clk = 1'b0;
    logic        sys_rst_n;
    logic        capture;
    logic [15:0] image_width;
    logic [15:0] image_height;
    logic        pix_valid;
    logic        pix_fval;
    logic        pix_lval;
    logic [15:0] pix_data;
    logic [63:0] m_axis_tdata;
    logic [7:0]  m_axis_tkeep;
    logic        m_axis_tlast;
    logic        m_axis_tvalid;
    logic        m_axis_tready;
    logic        busy;
    logic        frame_done;
    logic        err_overflow;
    logic        err_short;
    logic        err_cfg;

    always #5 sys_clk = ~sys_clk;

    hawk_axis_packer #(
        .PIX_W      (16),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .sys_clk       (sys_clk),
        .sys_rst_n     (sys_rst_n),
        .capture       (capture),
        .image_width   (image_width),
        .image_height  (image_height),
        .pix_valid     (pix_valid),
        .pix_fval      (pix_fval),
        .pix_lval      (pix_lval),
        .pix_data      (pix_data),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tkeep  (m_axis_tkeep),
        .m_axis_tlast  (m_axis_tlast),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .busy          (busy),
        .frame_done    (frame_done),
        .err_overflow  (err_overflow),
        .err_short     (err_short),
        .err_cfg       (err_cfg)
    );

    axis_beat_t q[$];
    int n_checks = 0;
    int n_fail   = 0;
    int n_done   = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] keep_mask(input logic [7:0] k);
        logic [63:0] m;
        m = '0;
        for (int i = 0; i < 8; i++) begin
            if (k[i]) m[8*i +: 8] = 8'hff;
        end
        return m;
    endfunction

    // Inputs change at the falling edge; outputs are sampled 1 ns later.
    task automatic step();
        axis_beat_t e;
        #1;
        if (frame_done === 1'b1) n_done++;
        if (m_axis_tvalid === 1'b1 && m_axis_tready === 1'b1) begin
            check("sb_beat_expected", 64'(q.size() > 0), 64'd1);
            if (q.size() > 0) begin
                e = q.pop_front();
                check("beat_tkeep", 64'(m_axis_tkeep), 64'(e.tkeep));
                check("beat_tlast", 64'(m_axis_tlast), 64'(e.tlast));
                check("beat_tdata", m_axis_tdata & keep_mask(e.tkeep), e.tdata);
            end
        end
        @(negedge sys_clk);
    endtask

    task automatic drive(input logic fv, input logic lv, input logic dv, input logic [15:0] d);
        pix_fval  = fv;
        pix_lval  = lv;
        pix_valid = dv;
        pix_data  = d;
        step();
    endtask

    task automatic arm(input int w, input int h);
        capture      = 1'b1;
        image_width  = 16'(w);
        image_height = 16'(h);
        step();
        capture = 1'b0;
    endtask

    // Frame with line blanking (DVAL high, LVAL low) and DVAL gaps; stop_after < 0 = full frame.
    task automatic send_frame(input int lines, input int wid, input int base, input int stop_after);
        int n;
        bit stop;
        n    = 0;
        stop = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 16'h0);
        drive(1'b0, 1'b0, 1'b0, 16'h0);
        for (int l = 0; l < lines && !stop; l++) begin
            drive(1'b1, 1'b0, 1'b1, 16'hbeef);
            for (int p = 0; p < wid && !stop; p++) begin
                if (n == stop_after) begin
                    stop = 1'b1;
                end else begin
                    drive(1'b1, 1'b1, 1'b1, 16'(base + n));
                    n++;
                    if (p % 3 == 1) drive(1'b1, 1'b1, 1'b0, 16'hdead);
                end
            end
        end
        drive(1'b0, 1'b0, 1'b0, 16'h0);
        drive(1'b0, 1'b0, 1'b0, 16'h0);
    endtask

    // Expected beats when n of total pixels (values base, base+1, ...) arrive.
    task automatic exp_frame(input int total, input int n, input int base);
        axis_beat_t b;
        int lane;
        b    = '0;
        lane = 0;
        for (int i = 0; i < n; i++) begin
            b.tdata[16*lane +: 16] = 16'(base + i);
            b.tkeep[2*lane +: 2]   = 2'b11;
            lane++;
            if (lane == 4 || i == total - 1) begin
                b.tlast = (i == total - 1);
                q.push_back(b);
                b    = '0;
                lane = 0;
            end
        end
        if (n < total) begin
            b.tlast = 1'b1;
            q.push_back(b);
        end
    endtask

    task automatic wait_idle(input string tag, input int budget);
        int k;
        k = 0;
        while ((busy !== 1'b0 || q.size() != 0) && k < budget) begin
            step();
            k++;
        end
        check(tag, 64'(busy === 1'b0 && q.size() == 0), 64'd1);
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_tdata"}, m_axis_tdata, 64'd0);
        check({tag, "_ctrl"}, 64'({m_axis_tkeep, m_axis_tlast, m_axis_tvalid, busy, frame_done,
                                   err_overflow, err_short, err_cfg}), 64'd0);
    endtask

    initial begin
        sys_rst_n     = 1'b0;
        capture       = 1'b0;
        image_width   = '0;
        image_height  = '0;
        pix_valid     = 1'b0;
        pix_fval      = 1'b0;
        pix_lval      = 1'b0;
        pix_data      = '0;
        m_axis_tready = 1'b0;
        #1;
        check_zero("reset");
        @(negedge sys_clk);
        @(negedge sys_clk);
        sys_rst_n = 1'b1;
        step();

        // 8x2 full frame, DMA always ready
        m_axis_tready = 1'b1;
        n_done = 0;
        arm(8, 2);
        check("t1_busy_armed", 64'(busy), 64'd1);
        exp_frame(16, 16, 0);
        send_frame(2, 8, 0, -1);
        wait_idle("t1_idle", 40);
        check("t1_frame_done", 64'(n_done), 64'd1);
        check("t1_errs", 64'({err_overflow, err_short, err_cfg}), 64'd0);

        // 5x1: partial final beat
        n_done = 0;
        arm(5, 1);
        exp_frame(5, 5, 'h40);
        send_frame(1, 5, 'h40, -1);
        wait_idle("t2_idle", 40);
        check("t2_frame_done", 64'(n_done), 64'd1);

        // 8x2 with fval dropped after 10 pixels
        n_done = 0;
        arm(8, 2);
        exp_frame(16, 10, 'h80);
        send_frame(2, 8, 'h80, 10);
        wait_idle("t3_idle", 40);
        check("t3_err_short", 64'(err_short), 64'd1);
        check("t3_frame_done", 64'(n_done), 64'd1);

        // capture mid-frame, second capture while busy, then zero-dimension capture
        n_done = 0;
        drive(1'b0, 1'b0, 1'b0, 16'h0);
        drive(1'b1, 1'b1, 1'b1, 16'h11);
        drive(1'b1, 1'b1, 1'b1, 16'h12);
        arm(4, 1);
        check("t4_short_cleared", 64'(err_short), 64'd0);
        check("t4_busy", 64'(busy), 64'd1);
        for (int i = 0; i < 3; i++) drive(1'b1, 1'b1, 1'b1, 16'(16'h13 + i));
        arm(1, 1);
        drive(1'b1, 1'b1, 1'b1, 16'h17);
        drive(1'b1, 1'b1, 1'b1, 16'h18);
        check("t4_no_midframe_beat", 64'(m_axis_tvalid), 64'd0);
        exp_frame(4, 4, 'hc0);
        send_frame(1, 4, 'hc0, -1);
        wait_idle("t4_idle", 40);
        check("t4_frame_done", 64'(n_done), 64'd1);
        arm(0, 5);
        step();
        check("t4_err_cfg", 64'(err_cfg), 64'd1);
        check("t4_busy_cfg", 64'(busy), 64'd0);

        // overflow with the DMA stalled: tlast beat is dropped and forced onto beat 4
        n_done = 0;
        m_axis_tready = 1'b0;
        arm(32, 1);
        check("t5_cfg_cleared", 64'(err_cfg), 64'd0);
        exp_frame(32, 32, 'h200);
        while (q.size() > 4) void'(q.pop_back());
        q[3].tlast = 1'b1;
        send_frame(1, 32, 'h200, -1);
        for (int i = 0; i < 4; i++) drive(1'b0, 1'b0, 1'b0, 16'h0);
        check("t5_tvalid_held", 64'(m_axis_tvalid), 64'd1);
        check("t5_err_overflow", 64'(err_overflow), 64'd1);
        check("t5_busy_drain", 64'(busy), 64'd1);
        check("t5_no_done_yet", 64'(n_done), 64'd0);
        m_axis_tready = 1'b1;
        wait_idle("t5_idle", 40);
        check("t5_frame_done", 64'(n_done), 64'd1);

        // reset mid-frame, then a clean 8x1 capture with latency checks
        m_axis_tready = 1'b0;
        arm(16, 1);
        drive(1'b0, 1'b0, 1'b0, 16'h0);
        for (int i = 0; i < 6; i++) drive(1'b1, 1'b1, 1'b1, 16'(16'h300 + i));
        check("t6_busy_pre", 64'(busy), 64'd1);
        check("t6_tvalid_pre", 64'(m_axis_tvalid), 64'd1);
        sys_rst_n = 1'b0;
        pix_fval  = 1'b0;
        pix_lval  = 1'b0;
        pix_valid = 1'b0;
        #1;
        check_zero("t6_reset");
        @(negedge sys_clk);
        @(negedge sys_clk);
        sys_rst_n     = 1'b1;
        m_axis_tready = 1'b1;
        step();
        n_done = 0;
        arm(8, 1);
        exp_frame(8, 8, 'h400);
        drive(1'b0, 1'b0, 1'b0, 16'h0);
        for (int i = 0; i < 4; i++) drive(1'b1, 1'b1, 1'b1, 16'(16'h400 + i));
        check("t6_lat_cycle1", 64'(m_axis_tvalid), 64'd0);
        drive(1'b1, 1'b1, 1'b1, 16'h404);
        check("t6_lat_cycle2", 64'(m_axis_tvalid), 64'd1);
        for (int i = 5; i < 8; i++) drive(1'b1, 1'b1, 1'b1, 16'(16'h400 + i));
        drive(1'b0, 1'b0, 1'b0, 16'h0);
        wait_idle("t6_idle", 40);
        check("t6_frame_done", 64'(n_done), 64'd1);
        check("t6_errs", 64'({err_overflow, err_short, err_cfg}), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
